// File: rtl/result_display.sv
// ---------------------------------------------------------------------------
// result_display
// Output side of the CORDIC datapath. Latches the signed 8-bit X/Y results
// when the core pulses done, converts the selected result to sign plus three
// BCD digits with a sequential double-dabble engine, and drives a 4-digit
// multiplexed seven-segment display plus a raw-value LED bank.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   done      one-cycle pulse: x_result/y_result valid this cycle
//   x_result  signed X result
//   y_result  signed Y result
//   btn_sel   one-cycle pulse: toggles displayed source (X <-> Y)
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   an        digit anodes, active-low, an[3] leftmost
//   leds      raw bits of the selected latched result
//   sel_y     0 = showing X, 1 = showing Y
//   valid     a result has been latched since reset
//   busy      conversion in progress
// ---------------------------------------------------------------------------
module result_display #(
   parameter int REFRESH_BITS = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       done,
   input  logic [7:0] x_result,
   input  logic [7:0] y_result,
   input  logic       btn_sel,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic [7:0] leds,
   output logic       sel_y,
   output logic       valid,
   output logic       busy
);

   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

   state_t      state_reg;
   logic [7:0]  x_reg;
   logic [7:0]  y_reg;
   logic        neg_reg;
   logic [7:0]  mag_reg;
   logic [11:0] bcd_reg;
   logic [2:0]  iter_reg;

   // Display-side copy, written only in COMMIT so partial BCD never shows.
   logic        disp_neg_reg;
   logic [11:0] disp_bcd_reg;

   logic [REFRESH_BITS-1:0] scan_reg;
   logic [REFRESH_BITS-1:0] scan_next;

   logic        trig;
   logic [7:0]  source;
   logic [11:0] bcd_adj;

   assign trig   = done | btn_sel;
   assign source = sel_y ? y_reg : x_reg;
   assign leds   = source;

   // Double-dabble correction: nibbles >= 5 get +3 before each shift.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 :
                                     bcd_reg[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         x_reg        <= '0;
         y_reg        <= '0;
         sel_y        <= 1'b0;
         valid        <= 1'b0;
         busy         <= 1'b0;
         neg_reg      <= 1'b0;
         mag_reg      <= '0;
         bcd_reg      <= '0;
         iter_reg     <= '0;
         disp_neg_reg <= 1'b0;
         disp_bcd_reg <= '0;
      end else begin
         if (done) begin
            x_reg <= x_result;
            y_reg <= y_result;
            valid <= 1'b1;
         end
         if (btn_sel) begin
            sel_y <= ~sel_y;
         end
         // A trigger in any state (including COMMIT) restarts at LOAD.
         if (trig) begin
            state_reg <= LOAD;
            busy      <= 1'b1;
         end else begin
            case (state_reg)
               LOAD: begin
                  neg_reg   <= source[7];
                  // 8-bit negate: -128 wraps to 8'h80, which is 128 unsigned.
                  mag_reg   <= source[7] ? (~source + 8'd1) : source;
                  bcd_reg   <= '0;
                  iter_reg  <= '0;
                  state_reg <= SHIFT;
               end
               SHIFT: begin
                  bcd_reg  <= {bcd_adj[10:0], mag_reg[7]};
                  mag_reg  <= {mag_reg[6:0], 1'b0};
                  iter_reg <= iter_reg + 3'd1;
                  if (iter_reg == 3'd7) begin
                     state_reg <= COMMIT;
                  end
               end
               COMMIT: begin
                  disp_neg_reg <= neg_reg;
                  disp_bcd_reg <= bcd_reg;
                  busy         <= 1'b0;
                  state_reg    <= IDLE;
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   // seg/an are decoded from the next counter value so the registered
   // outputs line up with the counter: each digit is lit while the top two
   // counter bits select it.
   assign scan_next = scan_reg + 1'b1;

   logic [1:0] digit_sel;
   logic [6:0] seg_sel;
   logic [3:0] an_sel;

   assign digit_sel = scan_next[REFRESH_BITS-1 -: 2];

   always_comb begin
      seg_sel = SEG_MINUS;
      an_sel  = 4'b1110;
      case (digit_sel)
         2'd3: begin
            an_sel  = 4'b0111;
            seg_sel = disp_neg_reg ? SEG_MINUS : SEG_BLANK;
         end
         2'd2: begin
            an_sel  = 4'b1011;
            seg_sel = seg_of(disp_bcd_reg[11:8]);
         end
         2'd1: begin
            an_sel  = 4'b1101;
            seg_sel = seg_of(disp_bcd_reg[7:4]);
         end
         default: begin
            an_sel  = 4'b1110;
            seg_sel = seg_of(disp_bcd_reg[3:0]);
         end
      endcase
      if (!valid) begin
         seg_sel = SEG_MINUS;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_reg <= '0;
         seg      <= SEG_MINUS;
         an       <= 4'b1110;
      end else begin
         scan_reg <= scan_next;
         seg      <= seg_sel;
         an       <= an_sel;
      end
   end

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

   logic       clk = 1'b0;
   logic       reset;
   logic       done;
   logic [7:0] x_result;
   logic [7:0] y_result;
   logic       btn_sel;
   logic [6:0] seg;
   logic [3:0] an;
   logic [7:0] leds;
   logic       sel_y;
   logic       valid;
   logic       busy;

   int errors = 0;
   int checks = 0;

   localparam logic [6:0] MINUS = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;

   result_display #(.REFRESH_BITS(4)) dut (
      .clk(clk), .reset(reset), .done(done), .x_result(x_result),
      .y_result(y_result), .btn_sel(btn_sel), .seg(seg), .an(an),
      .leds(leds), .sel_y(sel_y), .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] digit_code(input int v);
      logic [6:0] t [10];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return t[v];
   endfunction

   // Expected 4-digit pattern, leftmost digit in the top 7 bits.
   function automatic logic [27:0] exp_disp(input int v, input bit vld);
      int m;
      if (!vld) return {MINUS, MINUS, MINUS, MINUS};
      m = (v < 0) ? -v : v;
      return {(v < 0) ? MINUS : BLANK, digit_code(m / 100),
              digit_code((m / 10) % 10), digit_code(m % 10)};
   endfunction

   task automatic scan_display(output logic [27:0] got);
      got = 'x;
      for (int i = 0; i < 16; i++) begin
         case (an)
            4'b0111: got[27:21] = seg;
            4'b1011: got[20:14] = seg;
            4'b1101: got[13:7]  = seg;
            4'b1110: got[6:0]   = seg;
            default: ;
         endcase
         tick();
      end
   endtask

   // Counts cycles busy stays high, sampled starting right after the trigger edge.
   task automatic wait_busy(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic pulse(input logic d, input logic b, input logic [7:0] x, input logic [7:0] y);
      done = d; btn_sel = b; x_result = x; y_result = y;
      tick();
      done = 1'b0; btn_sel = 1'b0;
   endtask

   task automatic convert_check(input string tag, input int v);
      int n;
      logic [27:0] got;
      wait_busy(n);
      check({tag, "_busy_cycles"}, n, 10);
      scan_display(got);
      check({tag, "_display"}, got, exp_disp(v, 1'b1));
   endtask

   initial begin
      logic [3:0]  exp_an;
      logic [27:0] got;
      int          n;
      bit          saw5;

      reset = 1'b0; done = 1'b0; btn_sel = 1'b0; x_result = '0; y_result = '0;
      tick(); tick();
      reset = 1'b1;
      tick(); tick(); tick(); tick(); tick();

      // Test 1: reset mid-scan
      #2 reset = 1'b0;
      #1;
      check("rst_an", an, 4'b1110);
      check("rst_seg", seg, MINUS);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_sel_y", sel_y, 0);
      check("rst_leds", leds, 8'h00);
      @(posedge clk); #1 reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_an = (i < 4) ? 4'b1110 : (i < 8) ? 4'b1101 : (i < 12) ? 4'b1011 : 4'b0111;
         check($sformatf("scan_an_%0d", i), an, exp_an);
         check($sformatf("scan_seg_%0d", i), seg, MINUS);
         tick();
      end

      // Test 2: done with x=-128, y=100
      pulse(1'b1, 1'b0, 8'h80, 8'd100);
      check("t2_busy", busy, 1);
      check("t2_leds", leds, 8'h80);
      check("t2_valid", valid, 1);
      check("t2_sel_y", sel_y, 0);
      convert_check("t2", -128);

      // Test 3: toggle to Y
      pulse(1'b0, 1'b1, 8'h00, 8'h00);
      check("t3_sel_y", sel_y, 1);
      check("t3_leds", leds, 8'h64);
      convert_check("t3", 100);

      // Test 4: back to X, then a run of X values
      pulse(1'b0, 1'b1, 8'h00, 8'h00);
      check("t4_sel_y", sel_y, 0);
      convert_check("t4_back", -128);
      pulse(1'b1, 1'b0, 8'd0, 8'd0);
      convert_check("t4_x0", 0);
      pulse(1'b1, 1'b0, 8'd127, 8'd0);
      check("t4_leds127", leds, 8'h7f);
      convert_check("t4_x127", 127);
      pulse(1'b1, 1'b0, 8'hff, 8'd0);
      convert_check("t4_xm1", -1);

      // Test 5: retrigger mid-conversion
      pulse(1'b1, 1'b0, 8'hfb, 8'd0);
      saw5 = 0;
      for (int i = 0; i < 3; i++) begin
         if (an == 4'b1110 && seg == 7'b0010010) saw5 = 1;
         tick();
      end
      check("t5_busy_pre", busy, 1);
      pulse(1'b1, 1'b0, 8'd42, 8'd0);
      n = 0;
      while (busy && n < 40) begin
         if (an == 4'b1110 && seg == 7'b0010010) saw5 = 1;
         n++;
         tick();
      end
      check("t5_busy_cycles", n, 10);
      check("t5_no_m005", saw5, 0);
      scan_display(got);
      check("t5_display", got, exp_disp(42, 1'b1));

      // Test 6: done and btn_sel together, then reset during SHIFT
      pulse(1'b1, 1'b1, 8'd7, 8'hf7);
      check("t6_sel_y", sel_y, 1);
      check("t6_leds", leds, 8'hf7);
      convert_check("t6", -9);
      pulse(1'b1, 1'b0, 8'd50, 8'd60);
      tick(); tick(); tick();
      check("t6_busy_shift", busy, 1);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_valid", valid, 0);
      check("t6_rst_leds", leds, 8'h00);
      check("t6_rst_an", an, 4'b1110);
      check("t6_rst_seg", seg, MINUS);
      @(posedge clk); #1 reset = 1'b1;
      scan_display(got);
      check("t6_after_rst_display", got, exp_disp(0, 1'b0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
